// File: rtl/neuron_sequencer.sv
// neuron_sequencer: buffers N x/w pairs, drives the neuron start/load/ready handshake, returns the result.
// Optional NEU_TIMEOUT_EN adds a FEED watchdog that aborts to OUT with err set and a zero result.
module neuron_sequencer #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int RW      = 20,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x,
  input  logic [DW-1:0] s_w,
  output logic          neu_start,
  input  logic          neu_load,
  input  logic          neu_ready,
  input  logic [RW-1:0] neu_result,
  output logic [DW-1:0] neu_x,
  output logic [DW-1:0] neu_w,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [RW-1:0] m_result,
  output logic          err
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] NC   = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {FILL, START, FEED, OUT} state_t;
  state_t          state_q;
  logic [CW-1:0]   wr_cnt_q, rd_ptr_q, rd_ptr_d;
  logic [2*DW-1:0] buf_q [N];
  logic            s_ready_q, neu_start_q, m_valid_q, err_q;
  logic [RW-1:0]   m_result_q;
  logic            s_hs, last_wr;
`ifdef NEU_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_q;
`endif
  assign s_hs     = (state_q == FILL) && s_valid && s_ready_q;
  assign last_wr  = s_hs && (wr_cnt_q == LAST);
  // a load past the last pair is an error and must not move the pointer
  assign rd_ptr_d = (state_q == FEED && neu_load && rd_ptr_q != NC) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign {neu_x, neu_w} = (state_q == FEED && rd_ptr_q != NC) ? buf_q[rd_ptr_q[IW-1:0]] : '0;
  assign s_ready   = s_ready_q;
  assign neu_start = neu_start_q;
  assign m_valid   = m_valid_q;
  assign m_result  = m_result_q;
  assign err       = err_q;
  always_ff @(posedge clk)
    if (s_hs) buf_q[wr_cnt_q[IW-1:0]] <= {s_x, s_w};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      neu_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
      err_q       <= 1'b0;
`ifdef NEU_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      neu_start_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (s_hs) wr_cnt_q <= wr_cnt_q + 1'b1;
          s_ready_q <= !last_wr;
          if (last_wr) begin
            state_q     <= START;
            neu_start_q <= 1'b1;
          end
        end
        START: begin
          rd_ptr_q <= '0;
          state_q  <= FEED;
`ifdef NEU_TIMEOUT_EN
          wd_q     <= '0;
`endif
        end
        FEED: begin
          rd_ptr_q <= rd_ptr_d;
          if (neu_load && rd_ptr_q == NC) err_q <= 1'b1;
          if (neu_ready) begin
            m_result_q <= neu_result;
            m_valid_q  <= 1'b1;
            state_q    <= OUT;
            if (rd_ptr_d != NC) err_q <= 1'b1;
          end
`ifdef NEU_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            err_q      <= 1'b1;
            m_result_q <= '0;
            m_valid_q  <= 1'b1;
            state_q    <= OUT;
          end
          wd_q <= wd_q + 1'b1;
`endif
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            wr_cnt_q  <= '0;
            s_ready_q <= 1'b1;
            state_q   <= FILL;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: directed job vectors against neuron_sequencer with N=4 in the default build.
module tb_neuron_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_x = '0, s_w = '0;
  logic        neu_start, neu_load = 1'b0, neu_ready = 1'b0;
  logic [19:0] neu_result = '0;
  logic [7:0]  neu_x, neu_w;
  logic        m_valid, m_ready = 1'b0;
  logic [19:0] m_result;
  logic        err;
  int          vectors = 0, miscompares = 0, starts = 0;

  neuron_sequencer #(.N(4), .DW(8), .RW(20), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_w(s_w),
    .neu_start(neu_start), .neu_load(neu_load), .neu_ready(neu_ready),
    .neu_result(neu_result), .neu_x(neu_x), .neu_w(neu_w),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (neu_start) starts++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int b);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_x = 8'(b + 2 * i);
      s_w = 8'(b + 2 * i + 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("start_pulse", neu_start, 1);
    chk("s_ready_start", s_ready, 0);
    @(negedge clk);
    chk("start_one_cycle", neu_start, 0);
  endtask

  task automatic load(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      chk("neu_x", neu_x, (i < 4) ? 32'(b + 2 * i) : 0);
      chk("neu_w", neu_w, (i < 4) ? 32'(b + 2 * i + 1) : 0);
      neu_load = 1'b1;
      @(negedge clk);
      neu_load = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic deliver(input int res);
    neu_ready  = 1'b1;
    neu_result = 20'(res);
    @(negedge clk);
    neu_ready = 1'b0;
    chk("m_valid_out", m_valid, 1);
    chk("m_result_out", m_result, res);
  endtask

  task automatic accept();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_clr", m_valid, 0);
    chk("s_ready_fill", s_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_neu_x", neu_x, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_neu_start", neu_start, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("s_ready_first", s_ready, 0);
    @(negedge clk);
    chk("s_ready_up", s_ready, 1);
  endtask

  initial begin
    #1;
    chk("init_s_ready", s_ready, 0);
    chk("init_m_valid", m_valid, 0);
    chk("init_m_result", m_result, 0);
    chk("init_err", err, 0);
    chk("init_neu_start", neu_start, 0);
    chk("init_neu_x", neu_x, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("s_ready_first", s_ready, 0);
    @(negedge clk);
    chk("s_ready_up", s_ready, 1);
    // basic job
    fill(1);
    load(1, 4);
    chk("neu_x_end", neu_x, 0);
    deliver(100);
    chk("err_clean", err, 0);
    chk("start_count", starts, 1);
    // output backpressure with a stray neu_ready in OUT
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_result", m_result, 100);
      chk("hold_s_ready", s_ready, 0);
      neu_ready  = (i == 5);
      neu_result = 20'd999;
      @(negedge clk);
      neu_ready = 1'b0;
    end
    accept();
    // overrun: five loads
    fill(11);
    load(11, 5);
    chk("overrun_err", err, 1);
    chk("overrun_x", neu_x, 0);
    deliver(55);
    chk("overrun_err_sticky", err, 1);
    accept();
    // underrun: ready after three loads
    do_reset();
    fill(21);
    load(21, 3);
    chk("pre_underrun_err", err, 0);
    deliver(33);
    chk("underrun_err", err, 1);
    accept();
    // async reset mid-FEED, then a clean job with load+ready together
    fill(31);
    load(31, 2);
    chk("mid_x", neu_x, 35);
    do_reset();
    fill(41);
    load(41, 3);
    chk("last_x", neu_x, 47);
    neu_load   = 1'b1;
    neu_ready  = 1'b1;
    neu_result = 20'd77;
    @(negedge clk);
    neu_load  = 1'b0;
    neu_ready = 1'b0;
    chk("simul_err", err, 0);
    chk("simul_valid", m_valid, 1);
    chk("simul_result", m_result, 77);
    accept();
    chk("total_starts", starts, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
